mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the multi-cycle core.
- Operands come from the register-file read ports (latched A/B values); the result goes to the write-back mux that drives WD3.
- Controller pulses start, stalls the FSM while busy, and writes result to rd on done.
- One radix-2 shared datapath: shift-add multiply, restoring divide.

---
 rtl/mul_div_unit_pkg.sv | 20 ++
 rtl/mul_div_unit_if.sv | 25 ++
 rtl/mul_div_unit_negate.sv | 13 +
 rtl/mul_div_unit.sv | 195 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 operation codes and the controller state encoding.
package core_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } md_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the core controller (master) and the
// multiply/divide unit (slave).
interface mul_div_unit_if #(
    parameter int width = 32
);

    logic             start;
    logic [2:0]       funct3;
    logic [width-1:0] src_a;
    logic [width-1:0] src_b;
    logic             busy;
    logic             done;
    logic [width-1:0] result;

    modport master (
        output start, funct3, src_a, src_b,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, src_a, src_b,
        output busy, done, result
    );

endinterface

// File: rtl/mul_div_unit_negate.sv
// Conditional two's-complement negation, used both to form operand
// magnitudes and to restore the sign of the final result.
module md_negate #(
    parameter int width = 32
) (
    input  logic [width-1:0] value_i,
    input  logic             neg_i,
    output logic [width-1:0] value_o
);

    assign value_o = neg_i ? ((~value_i) + width'(1)) : value_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: shift-add multiply and
// restoring divide share one hi/lo shift datapath, one bit per cycle.
module mul_div_unit
    import core_pkg::*;
#(
    parameter int width = 32
) (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus
);

    localparam int CW = $clog2(width) + 1;
    localparam logic [width-1:0] MIN_NEG = {1'b1, {(width-1){1'b0}}};

    md_state_e        state_q;
    logic [2:0]       op_q;
    logic             signA_q;
    logic             signB_q;
    logic [width-1:0] magB_q;
    logic [width-1:0] hi_q;
    logic [width-1:0] lo_q;
    logic [width-1:0] result_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;

    logic [width-1:0] hi_d;
    logic [width-1:0] lo_d;

    logic             aSigned;
    logic             bSigned;
    logic             signAIn;
    logic             signBIn;
    logic [width-1:0] magAIn;
    logic [width-1:0] magBIn;
    logic             isSpecial;
    logic [width-1:0] specialRes;

    logic [2*width-1:0] prodFix;
    logic [width-1:0]   quoFix;
    logic [width-1:0]   remFix;
    logic [width-1:0]   finalRes;

    logic [width:0]     mulSum;
    logic [width:0]     divShift;

    always_comb begin
        aSigned = (bus.funct3 == MD_MULH) || (bus.funct3 == MD_MULHSU) ||
                  (bus.funct3 == MD_DIV)  || (bus.funct3 == MD_REM);
        bSigned = (bus.funct3 == MD_MULH) || (bus.funct3 == MD_DIV) ||
                  (bus.funct3 == MD_REM);
        signAIn = aSigned && bus.src_a[width-1];
        signBIn = bSigned && bus.src_b[width-1];
    end

    md_negate #(.width(width)) uNegA (
        .value_i (bus.src_a),
        .neg_i   (signAIn),
        .value_o (magAIn)
    );

    md_negate #(.width(width)) uNegB (
        .value_i (bus.src_b),
        .neg_i   (signBIn),
        .value_o (magBIn)
    );

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    always_comb begin
        isSpecial  = 1'b0;
        specialRes = '0;
        if (bus.funct3[2] && (bus.src_b == '0)) begin
            isSpecial  = 1'b1;
            specialRes = bus.funct3[1] ? bus.src_a : '1;
        end else if (((bus.funct3 == MD_DIV) || (bus.funct3 == MD_REM)) &&
                     (bus.src_a == MIN_NEG) && (bus.src_b == '1)) begin
            isSpecial  = 1'b1;
            specialRes = bus.funct3[1] ? '0 : bus.src_a;
        end
    end

    // lo holds multiplier/dividend; magB is addend/divisor.
    always_comb begin
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, magB_q} : '0);
        divShift = {hi_q, lo_q[width-1]};
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (op_q[2]) begin
            if (divShift >= {1'b0, magB_q}) begin
                hi_d = divShift[width-1:0] - magB_q;
                lo_d = {lo_q[width-2:0], 1'b1};
            end else begin
                hi_d = divShift[width-1:0];
                lo_d = {lo_q[width-2:0], 1'b0};
            end
        end else begin
            hi_d = mulSum[width:1];
            lo_d = {mulSum[0], lo_q[width-1:1]};
        end
    end

    md_negate #(.width(2*width)) uNegProd (
        .value_i ({hi_d, lo_d}),
        .neg_i   (signA_q ^ signB_q),
        .value_o (prodFix)
    );

    md_negate #(.width(width)) uNegQuo (
        .value_i (lo_d),
        .neg_i   (signA_q ^ signB_q),
        .value_o (quoFix)
    );

    md_negate #(.width(width)) uNegRem (
        .value_i (hi_d),
        .neg_i   (signA_q),
        .value_o (remFix)
    );

    always_comb begin
        finalRes = '0;
        case (op_q)
            MD_MUL:                         finalRes = prodFix[width-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:   finalRes = prodFix[2*width-1:width];
            MD_DIV, MD_DIVU:                finalRes = quoFix;
            default:                        finalRes = remFix;
        endcase
    end

    // The corrected result is registered on the edge into FIN so that
    // result and done are both valid throughout the FIN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            signA_q  <= 1'b0;
            signB_q  <= 1'b0;
            magB_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.funct3;
                        signA_q <= signAIn;
                        signB_q <= signBIn;
                        magB_q  <= magBIn;
                        hi_q    <= '0;
                        lo_q    <= magAIn;
                        busy_q  <= 1'b1;
                        if (isSpecial) begin
                            result_q <= specialRes;
                            done_q   <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= FIN;
                        end else begin
                            cnt_q   <= CW'(width);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q <= finalRes;
                        done_q   <= 1'b1;
                        state_q  <= FIN;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected results are queued at
// issue and compared whenever the unit pulses done.
module tb_mul_div_unit;
    import core_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mul_div_unit_if #(.width(WIDTH)) bus ();

    mul_div_unit #(.width(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [WIDTH-1:0] expQ[$];
    logic [WIDTH-1:0] monExp;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Independent reference built on 64-bit host arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa;
        longint sb;
        longint ub;
        logic [63:0] p;
        int q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (f3)
            MD_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0];  end
            MD_MULH:   begin p = sa * sb;                 return p[63:32]; end
            MD_MULHSU: begin p = sa * ub;                 return p[63:32]; end
            MD_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            MD_DIV: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = $signed(a) / $signed(b);
                return 32'(q);
            end
            MD_DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            MD_REM: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = $signed(a) % $signed(b);
                return 32'(q);
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        if (f3[2] && b == 32'h0) return 1;
        if ((f3 == MD_DIV || f3 == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return WIDTH + 1;
    endfunction

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_done", 64'(expQ.size()), 64'd1);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("result", 64'(bus.result), 64'(monExp));
            end
        end
    end

    // Issue one op, then watch done timing and busy coverage of the op.
    task automatic applyStimulus(input string tag, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input int expCycle);
        int doneCycle  = 0;
        int busyCycles = 0;
        @(posedge clk); #1;
        bus.funct3 = f3;
        bus.src_a  = a;
        bus.src_b  = b;
        bus.start  = 1'b1;
        expQ.push_back(expRes);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 100 && doneCycle == 0; c++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busyCycles++;
            if (bus.done === 1'b1) doneCycle = c;
        end
        checkOutput({tag, "_doneCycle"}, 64'(doneCycle), 64'(expCycle));
        checkOutput({tag, "_busyCycles"}, 64'(busyCycles), 64'(expCycle));
        @(negedge clk);
        checkOutput({tag, "_busyAfter"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int dones;
        int firstDone;
        int secondDone;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.funct3 = 3'b000;
        bus.src_a  = '0;
        bus.src_b  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_result", 64'(bus.result), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] directed multiply/divide cases");
        applyStimulus("mul_7x-3",   MD_MUL,    32'h7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        applyStimulus("mulh_m1",    MD_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33);
        applyStimulus("mulhu_m1",   MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        applyStimulus("mulhsu_m1",  MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        applyStimulus("div_-7/2",   MD_DIV,    32'hFFFF_FFF9,  32'h2,         32'hFFFF_FFFD, 33);
        applyStimulus("rem_-7/2",   MD_REM,    32'hFFFF_FFF9,  32'h2,         32'hFFFF_FFFF, 33);
        applyStimulus("divu_big",   MD_DIVU,   32'hFFFF_FFFF,  32'h10,        32'h0FFF_FFFF, 33);
        applyStimulus("remu_big",   MD_REMU,   32'hFFFF_FFFF,  32'h10,        32'h0000_000F, 33);

        $display("[TB] special cases");
        applyStimulus("divu_by0",   MD_DIVU,   32'h5,          32'h0,         32'hFFFF_FFFF, 1);
        applyStimulus("rem_by0",    MD_REM,    32'h5,          32'h0,         32'h0000_0005, 1);
        applyStimulus("div_ovf",    MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        applyStimulus("rem_ovf",    MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1);

        $display("[TB] random ops against reference model");
        for (int i = 0; i < 8; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 300));
            applyStimulus($sformatf("rand%0d", i), rf3, ra, rb,
                          refModel(rf3, ra, rb), refLatency(rf3, ra, rb));
        end

        $display("[TB] start held high for 40 cycles");
        dones      = 0;
        firstDone  = 0;
        secondDone = 0;
        @(posedge clk); #1;
        bus.funct3 = MD_MUL;
        bus.src_a  = 32'd3;
        bus.src_b  = 32'd4;
        bus.start  = 1'b1;
        expQ.push_back(32'd12);
        expQ.push_back(32'd12);
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            if (c == 40) bus.start = 1'b0;
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dones++;
                if (dones == 1) firstDone = c;
                else if (dones == 2) secondDone = c;
            end
        end
        checkOutput("held_doneCount", 64'(dones), 64'd2);
        checkOutput("held_firstDone", 64'(firstDone), 64'd33);
        checkOutput("held_secondDone", 64'(secondDone), 64'd67);

        $display("[TB] reset during divide");
        @(posedge clk); #1;
        bus.funct3 = MD_DIV;
        bus.src_a  = 32'd1000;
        bus.src_b  = 32'd3;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        checkOutput("rst_result", 64'(bus.result), 64'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        checkOutput("rst_noDone", 64'(dones), 64'd0);
        applyStimulus("divu_after_rst", MD_DIVU, 32'd100, 32'd7, 32'd14, 33);

        repeat (2) @(negedge clk);
        checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
